// File: rtl/adder.sv
// Up-counter with synchronous reset, synchronous clear and increment enable.
// Count wraps modulo 2^WIDTH; out is the count register itself.
module adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             aclk,
  input  logic             arstn,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] out
);

  localparam int unsigned MIN_WIDTH = 1;
  localparam int unsigned MAX_WIDTH = 32;

  if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("adder: WIDTH must be in 1..32");
  end

  logic [WIDTH-1:0] count;

  // arstn is active-high despite its name; priority is reset > clr > inc > hold.
  always_ff @(posedge aclk) begin
    if (arstn) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + WIDTH'(1);
    end
  end

  assign out = count;

endmodule

// File: tb/tb_adder.sv
// Directed self-checking bench for the adder counter (WIDTH=8).
module tb_adder;

  logic       aclk;
  logic       arstn;
  logic       clr;
  logic       inc;
  logic [7:0] out;

  int checks;
  int errors;

  adder #(.WIDTH(8)) dut (
    .aclk (aclk),
    .arstn(arstn),
    .clr  (clr),
    .inc  (inc),
    .out  (out)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic do_reset();
    arstn = 1'b1;
    clr   = 1'b0;
    inc   = 1'b0;
    tick();
    arstn = 1'b0;
  endtask

  task automatic test_reset();
    arstn = 1'b1;
    clr   = 1'b0;
    inc   = 1'b0;
    for (int i = 0; i < 25; i++) begin
      tick();
      checks++;
      if (out !== 8'd0) begin
        errors++;
        $display("FAIL reset_hold cycle %0d: got %0d expected 0", i, out);
      end
    end
    arstn = 1'b0;
    #1;
    checks++;
    if (out !== 8'd0) begin
      errors++;
      $display("FAIL reset_release: got %0d expected 0", out);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (out !== 8'd0) begin
        errors++;
        $display("FAIL post_reset_idle %0d: got %0d expected 0", i, out);
      end
    end
  endtask

  task automatic test_single_inc();
    do_reset();
    inc = 1'b1;
    tick();
    inc = 1'b0;
    checks++;
    if (out !== 8'd1) begin
      errors++;
      $display("FAIL single_inc: got %0d expected 1", out);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (out !== 8'd1) begin
        errors++;
        $display("FAIL single_inc_hold %0d: got %0d expected 1", i, out);
      end
    end
  endtask

  task automatic test_wrap();
    logic [7:0] expected;
    do_reset();
    inc = 1'b1;
    for (int i = 1; i <= 256; i++) begin
      tick();
      expected = (i == 256) ? 8'd0 : 8'(i);
      checks++;
      if (out !== expected) begin
        errors++;
        $display("FAIL wrap step %0d: got %0d expected %0d", i, out, expected);
      end
    end
    inc = 1'b0;
    tick();
    checks++;
    if (out !== 8'd0) begin
      errors++;
      $display("FAIL wrap_hold: got %0d expected 0", out);
    end
  endtask

  task automatic test_clr_inc();
    do_reset();
    inc = 1'b1;
    repeat (5) tick();
    checks++;
    if (out !== 8'd5) begin
      errors++;
      $display("FAIL clr_pre_count: got %0d expected 5", out);
    end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    checks++;
    if (out !== 8'd0) begin
      errors++;
      $display("FAIL clr_with_inc: got %0d expected 0", out);
    end
    tick();
    checks++;
    if (out !== 8'd1) begin
      errors++;
      $display("FAIL clr_resume: got %0d expected 1", out);
    end
    inc = 1'b0;
    tick();
    checks++;
    if (out !== 8'd1) begin
      errors++;
      $display("FAIL idle_hold: got %0d expected 1", out);
    end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    checks++;
    if (out !== 8'd0) begin
      errors++;
      $display("FAIL clr_alone: got %0d expected 0", out);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    inc = 1'b1;
    repeat (7) tick();
    checks++;
    if (out !== 8'd7) begin
      errors++;
      $display("FAIL mid_pre_count: got %0d expected 7", out);
    end
    arstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (out !== 8'd0) begin
        errors++;
        $display("FAIL mid_reset %0d: got %0d expected 0", i, out);
      end
    end
    arstn = 1'b0;
    tick();
    checks++;
    if (out !== 8'd1) begin
      errors++;
      $display("FAIL mid_release: got %0d expected 1", out);
    end
    inc = 1'b0;
  endtask

  task automatic test_between_edges();
    do_reset();
    inc = 1'b1;
    repeat (3) tick();
    inc = 1'b0;
    checks++;
    if (out !== 8'd3) begin
      errors++;
      $display("FAIL between_pre: got %0d expected 3", out);
    end
    inc = 1'b1;
    #2;
    checks++;
    if (out !== 8'd3) begin
      errors++;
      $display("FAIL between_inc: got %0d expected 3", out);
    end
    clr = 1'b1;
    #2;
    checks++;
    if (out !== 8'd3) begin
      errors++;
      $display("FAIL between_clr: got %0d expected 3", out);
    end
    clr   = 1'b0;
    arstn = 1'b1;
    #2;
    checks++;
    if (out !== 8'd3) begin
      errors++;
      $display("FAIL between_rst: got %0d expected 3", out);
    end
    arstn = 1'b0;
    tick();
    checks++;
    if (out !== 8'd4) begin
      errors++;
      $display("FAIL between_edge: got %0d expected 4", out);
    end
    inc = 1'b0;
    #3;
    inc = 1'b1;
    #2;
    clr = 1'b1;
    #1;
    clr = 1'b0;
    inc = 1'b0;
    checks++;
    if (out !== 8'd4) begin
      errors++;
      $display("FAIL between_glitch: got %0d expected 4", out);
    end
    tick();
    checks++;
    if (out !== 8'd4) begin
      errors++;
      $display("FAIL between_glitch_edge: got %0d expected 4", out);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    arstn  = 1'b1;
    clr    = 1'b0;
    inc    = 1'b0;
    test_reset();
    test_single_inc();
    test_wrap();
    test_clr_inc();
    test_reset_mid();
    test_between_edges();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
